// File: rtl/ppm_pkg.sv
// Shared PPM framing definitions, imported by both transmitter and receiver.
package ppm_pkg;

  typedef enum logic [1:0] {IDLE, PRE, DATA, PAR} state_t;

  // Preamble symbol value: the last slot of the symbol (2^n_mod - 1).
  function automatic int pre_sym(input int n_mod);
    return (1 << n_mod) - 1;
  endfunction

  // Payload symbols per packet.
  function automatic int syms_per_pkt(input int n_pkt, input int n_mod);
    return n_pkt / n_mod;
  endfunction

endpackage

// File: rtl/ppm_slot_timer.sv
// Cycle-in-slot and slot-in-symbol counters for the PPM transmitter.
// Produces the current slot, the pulse window and the symbol-end strobe.
module ppm_slot_timer #(
  parameter int L        = 10000,
  parameter int N_MOD    = 2,
  parameter int PULSE_CT = 7500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [N_MOD-1:0] slot,
  output logic             win,
  output logic             sym_end
);
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  logic [CW-1:0] cyc;
  logic          slot_end;

  assign slot_end = (cyc == CW'(L - 1));
  // PULSE_CT may equal L, so compare at 32 bits rather than CW bits
  assign win      = (32'(cyc) < PULSE_CT);
  assign sym_end  = en && slot_end && (slot == '1);

  // Counters clear on frame start, advance while enabled; slot wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= '0;
      slot <= '0;
    end else if (clr) begin
      cyc  <= '0;
      slot <= '0;
    end else if (en) begin
      if (slot_end) begin
        cyc  <= '0;
        slot <= slot + 1'b1;
      end else begin
        cyc  <= cyc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ppm_transmitter.sv
// PPM transmitter: preamble, MSB-first payload symbols, optional parity symbol.
// Optional feature macro: PPM_TX_PARITY_EN (adds an even-parity symbol after DATA).
module ppm_transmitter
  import ppm_pkg::*;
#(
  parameter int PULSE_CT = 7500,
  parameter int N_MOD    = 2,
  parameter int L        = 10000,
  parameter int N_PKT    = 8,
  parameter int PRE_CT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_PKT-1:0] data,
  input  logic             start,
  output logic             avail,
  output logic             pulse
);
  localparam int NS   = syms_per_pkt(N_PKT, N_MOD);
  localparam int MAXC = (PRE_CT > NS) ? PRE_CT : NS;
  localparam int SW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [N_MOD-1:0] PRE_SYM = N_MOD'(pre_sym(N_MOD));

  state_t           state, state_n;
  logic [N_PKT-1:0] sreg;
  logic [SW-1:0]    sym_cnt;
  logic [N_MOD-1:0] slot, cur_sym;
  logic             win, sym_end, active, accept, last_sym;
`ifdef PPM_TX_PARITY_EN
  logic             par;
`endif

  assign active = (state != IDLE);
  assign avail  = !active;
  assign accept = !active && start;

  ppm_slot_timer #(.L(L), .N_MOD(N_MOD), .PULSE_CT(PULSE_CT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (active),
    .clr     (accept),
    .slot    (slot),
    .win     (win),
    .sym_end (sym_end)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, current symbol value and end-of-phase detection
  always_comb begin
    state_n  = state;
    cur_sym  = '0;
    last_sym = 1'b1;
    case (state)
      IDLE: if (start) state_n = PRE;
      PRE: begin
        cur_sym  = PRE_SYM;
        last_sym = (sym_cnt == SW'(PRE_CT - 1));
        if (sym_end && last_sym) state_n = DATA;
      end
      DATA: begin
        cur_sym  = sreg[N_PKT-1 -: N_MOD];
        last_sym = (sym_cnt == SW'(NS - 1));
`ifdef PPM_TX_PARITY_EN
        if (sym_end && last_sym) state_n = PAR;
`else
        if (sym_end && last_sym) state_n = IDLE;
`endif
      end
`ifdef PPM_TX_PARITY_EN
      PAR: begin
        cur_sym = N_MOD'(par);
        if (sym_end) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Payload shift register, symbol counter and registered pulse line.
  // pulse is computed from this cycle's counters, so it lands one cycle
  // after the counters; the counters clear on acceptance to absorb that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      sym_cnt <= '0;
      pulse   <= 1'b0;
`ifdef PPM_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      pulse <= active && win && (slot == cur_sym);
      if (accept) begin
        sreg    <= data;
        sym_cnt <= '0;
`ifdef PPM_TX_PARITY_EN
        par     <= ^data;
`endif
      end else if (sym_end) begin
        sym_cnt <= last_sym ? '0 : sym_cnt + 1'b1;
        if (state == DATA) sreg <= sreg << N_MOD;
      end
    end
  end

endmodule
